// File: rtl/cr_huf_comp_is_arb_pkg.sv
// ============================================================================
// Module : cr_huf_compPKG
// Brief  : Shared types for the Huffman insertion-sort arbiter: pipeline EOB
//          encoding, arbiter state enum and last-beat classification helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cr_huf_compPKG;

    localparam int CREOLE_HC_SEQID_WIDTH = 8;

    typedef enum logic [1:0] {
        EOB_MIDDLE   = 2'd0,
        EOB_LAST     = 2'd1,
        EOB_LAST_PAD = 2'd2,
        EOB_RSVD     = 2'd3
    } e_pipe_eob;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Both flavours of end-of-block close a frame; padding only affects downstream.
    function automatic logic huf_is_last_eob(input e_pipe_eob eob);
        return (eob == EOB_LAST) || (eob == EOB_LAST_PAD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cr_huf_comp_is_arb_rr.sv
// ============================================================================
// Module : cr_huf_comp_is_arb_rr
// Brief  : Two-way frame-level round-robin picker with last-grant register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_huf_comp_is_arb_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_src,
    output logic [1:0] pick
);

    // 1 means source 1 owned the most recent frame; reset favours source 0.
    logic last_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_src <= 1'b1;
        end else if (upd) begin
            last_src <= upd_src;
        end
    end

    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = last_src ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cr_huf_comp_is_arb.sv
// ============================================================================
// Module : cr_huf_comp_is_arb
// Brief  : Frame-level arbiter feeding two symbol sources into one shared
//          insertion-sort engine, with in-flight frame throttling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_huf_comp_is_arb
    import cr_huf_compPKG::*;
#(
    parameter int DAT_WIDTH      = 10,
    parameter int CNT_WIDTH      = 3,
    parameter int CNTRL_WIDTH    = 1,
    parameter int NUM_IN_SYMBOLS = 4,
    parameter int MAX_INFLIGHT   = 2
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic [NUM_IN_SYMBOLS-1:0]           sc0_is_vld,
    input  logic [NUM_IN_SYMBOLS*DAT_WIDTH-1:0] sc0_is_sym,
    input  logic [NUM_IN_SYMBOLS*CNT_WIDTH-1:0] sc0_is_cnt,
    input  logic [CNTRL_WIDTH-1:0]              sc0_is_meta,
    input  logic [CREOLE_HC_SEQID_WIDTH-1:0]    sc0_is_seq_id,
    input  e_pipe_eob                           sc0_is_eob,
    output logic                                is_sc0_rd,

    input  logic [NUM_IN_SYMBOLS-1:0]           sc1_is_vld,
    input  logic [NUM_IN_SYMBOLS*DAT_WIDTH-1:0] sc1_is_sym,
    input  logic [NUM_IN_SYMBOLS*CNT_WIDTH-1:0] sc1_is_cnt,
    input  logic [CNTRL_WIDTH-1:0]              sc1_is_meta,
    input  logic [CREOLE_HC_SEQID_WIDTH-1:0]    sc1_is_seq_id,
    input  e_pipe_eob                           sc1_is_eob,
    output logic                                is_sc1_rd,

    output logic [NUM_IN_SYMBOLS-1:0]           arb_is_vld,
    output logic [NUM_IN_SYMBOLS*DAT_WIDTH-1:0] arb_is_sym,
    output logic [NUM_IN_SYMBOLS*CNT_WIDTH-1:0] arb_is_cnt,
    output logic [CNTRL_WIDTH-1:0]              arb_is_meta,
    output logic [CREOLE_HC_SEQID_WIDTH-1:0]    arb_is_seq_id,
    output e_pipe_eob                           arb_is_eob,
    input  logic                                is_arb_rd,
    input  logic                                is_done,

    output logic [1:0]                          arb_grant,
    output logic [1:0]                          arb_inflight,
    output logic [15:0]                         arb_frames0,
    output logic [15:0]                         arb_frames1,
    output logic                                arb_err_seq
);

    localparam logic [31:0] MAX_INFLIGHT_U = 32'(MAX_INFLIGHT);

    arb_state_e                       state;
    logic                             first_beat;
    logic [CREOLE_HC_SEQID_WIDTH-1:0] seq_lat;
    logic [1:0]                       req;
    logic [1:0]                       pick;
    logic                             can_grant;
    logic                             xfer;
    logic                             last_xfer;
    logic                             dec_inflight;

    assign req       = {|sc1_is_vld, |sc0_is_vld};
    assign can_grant = ({30'd0, arb_inflight} < MAX_INFLIGHT_U);

    // Pass-through to the engine: zero latency, only the owner is visible.
    always_comb begin
        arb_is_vld    = '0;
        arb_is_sym    = '0;
        arb_is_cnt    = '0;
        arb_is_meta   = '0;
        arb_is_seq_id = '0;
        arb_is_eob    = EOB_MIDDLE;
        is_sc0_rd     = 1'b0;
        is_sc1_rd     = 1'b0;
        if (state == XFER && arb_grant[0]) begin
            arb_is_vld    = sc0_is_vld;
            arb_is_sym    = sc0_is_sym;
            arb_is_cnt    = sc0_is_cnt;
            arb_is_meta   = sc0_is_meta;
            arb_is_seq_id = sc0_is_seq_id;
            arb_is_eob    = sc0_is_eob;
            is_sc0_rd     = is_arb_rd && (|sc0_is_vld);
        end else if (state == XFER && arb_grant[1]) begin
            arb_is_vld    = sc1_is_vld;
            arb_is_sym    = sc1_is_sym;
            arb_is_cnt    = sc1_is_cnt;
            arb_is_meta   = sc1_is_meta;
            arb_is_seq_id = sc1_is_seq_id;
            arb_is_eob    = sc1_is_eob;
            is_sc1_rd     = is_arb_rd && (|sc1_is_vld);
        end
    end

    assign xfer         = (|arb_is_vld) && is_arb_rd;
    assign last_xfer    = xfer && huf_is_last_eob(arb_is_eob);
    assign dec_inflight = is_done && (arb_inflight != 2'd0);

    cr_huf_comp_is_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .upd     (last_xfer),
        .upd_src (arb_grant[1]),
        .pick    (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            arb_grant    <= 2'b00;
            arb_inflight <= 2'd0;
            arb_frames0  <= 16'd0;
            arb_frames1  <= 16'd0;
            arb_err_seq  <= 1'b0;
            first_beat   <= 1'b1;
            seq_lat      <= '0;
        end else begin
            case (state)
                ARB: begin
                    if ((|pick) && can_grant) begin
                        arb_grant  <= pick;
                        state      <= XFER;
                        first_beat <= 1'b1;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        first_beat <= 1'b0;
                        if (first_beat) begin
                            seq_lat <= arb_is_seq_id;
                        end else if (arb_is_seq_id != seq_lat) begin
                            arb_err_seq <= 1'b1;
                        end
                        if (last_xfer) begin
                            state     <= ARB;
                            arb_grant <= 2'b00;
                            if (arb_grant[0] && arb_frames0 != 16'hFFFF) begin
                                arb_frames0 <= arb_frames0 + 16'd1;
                            end
                            if (arb_grant[1] && arb_frames1 != 16'hFFFF) begin
                                arb_frames1 <= arb_frames1 + 16'd1;
                            end
                        end
                    end
                end
                default: state <= ARB;
            endcase

            // A frame entering and one leaving in the same cycle cancel out.
            case ({last_xfer, dec_inflight})
                2'b10:   arb_inflight <= arb_inflight + 2'd1;
                2'b01:   arb_inflight <= arb_inflight - 2'd1;
                default: arb_inflight <= arb_inflight;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cr_huf_comp_is_arb.sv
// ============================================================================
// Module : tb_cr_huf_comp_is_arb
// Brief  : Self-checking bench for cr_huf_comp_is_arb against a frame-level
//          reference model driven from per-source beat queues.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cr_huf_comp_is_arb;
    import cr_huf_compPKG::*;

    localparam int DW = 10;
    localparam int CW = 3;
    localparam int MW = 1;
    localparam int NS = 4;
    localparam int MI = 2;
    localparam int SW = CREOLE_HC_SEQID_WIDTH;

    typedef struct {
        logic [NS-1:0]    vld;
        logic [NS*DW-1:0] sym;
        logic [NS*CW-1:0] cnt;
        logic [MW-1:0]    meta;
        logic [SW-1:0]    seq;
        e_pipe_eob        eob;
        bit               last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NS-1:0] sc0_is_vld, sc1_is_vld;
    logic [NS*DW-1:0] sc0_is_sym, sc1_is_sym;
    logic [NS*CW-1:0] sc0_is_cnt, sc1_is_cnt;
    logic [MW-1:0] sc0_is_meta, sc1_is_meta;
    logic [SW-1:0] sc0_is_seq_id, sc1_is_seq_id;
    e_pipe_eob sc0_is_eob, sc1_is_eob;
    logic is_sc0_rd, is_sc1_rd;
    logic [NS-1:0] arb_is_vld;
    logic [NS*DW-1:0] arb_is_sym;
    logic [NS*CW-1:0] arb_is_cnt;
    logic [MW-1:0] arb_is_meta;
    logic [SW-1:0] arb_is_seq_id;
    e_pipe_eob arb_is_eob;
    logic is_arb_rd, is_done;
    logic [1:0] arb_grant, arb_inflight;
    logic [15:0] arb_frames0, arb_frames1;
    logic arb_err_seq;

    always #5 clk = ~clk;

    cr_huf_comp_is_arb #(
        .DAT_WIDTH(DW), .CNT_WIDTH(CW), .CNTRL_WIDTH(MW),
        .NUM_IN_SYMBOLS(NS), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .rst(rst),
        .sc0_is_vld(sc0_is_vld), .sc0_is_sym(sc0_is_sym), .sc0_is_cnt(sc0_is_cnt),
        .sc0_is_meta(sc0_is_meta), .sc0_is_seq_id(sc0_is_seq_id), .sc0_is_eob(sc0_is_eob),
        .is_sc0_rd(is_sc0_rd),
        .sc1_is_vld(sc1_is_vld), .sc1_is_sym(sc1_is_sym), .sc1_is_cnt(sc1_is_cnt),
        .sc1_is_meta(sc1_is_meta), .sc1_is_seq_id(sc1_is_seq_id), .sc1_is_eob(sc1_is_eob),
        .is_sc1_rd(is_sc1_rd),
        .arb_is_vld(arb_is_vld), .arb_is_sym(arb_is_sym), .arb_is_cnt(arb_is_cnt),
        .arb_is_meta(arb_is_meta), .arb_is_seq_id(arb_is_seq_id), .arb_is_eob(arb_is_eob),
        .is_arb_rd(is_arb_rd), .is_done(is_done),
        .arb_grant(arb_grant), .arb_inflight(arb_inflight),
        .arb_frames0(arb_frames0), .arb_frames1(arb_frames1),
        .arb_err_seq(arb_err_seq)
    );

    int errors = 0;
    int checks = 0;

    beat_t q0[$];
    beat_t q1[$];

    // Reference model: owner -1 = nobody, pref = source that wins a tie.
    int m_owner;
    int m_pref;
    int m_infl;
    int m_frames[2];
    bit m_err;
    bit m_first;
    logic [SW-1:0] m_seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic beat_t idle_beat();
        beat_t b;
        b.vld = '0; b.sym = '0; b.cnt = '0; b.meta = '0; b.seq = '0;
        b.eob = EOB_MIDDLE; b.last = 1'b0;
        return b;
    endfunction

    task automatic drive(input int s, input beat_t b);
        if (s == 0) begin
            sc0_is_vld = b.vld; sc0_is_sym = b.sym; sc0_is_cnt = b.cnt;
            sc0_is_meta = b.meta; sc0_is_seq_id = b.seq; sc0_is_eob = b.eob;
        end else begin
            sc1_is_vld = b.vld; sc1_is_sym = b.sym; sc1_is_cnt = b.cnt;
            sc1_is_meta = b.meta; sc1_is_seq_id = b.seq; sc1_is_eob = b.eob;
        end
    endtask

    // bad: the final beat of a multi-beat frame carries seq+1.
    task automatic gen_frame(input int s, input int n, input bit bad, input logic [SW-1:0] sq);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.vld  = 4'($urandom_range(1, 15));
            b.sym  = {8'($urandom), 32'($urandom)};
            b.cnt  = 12'($urandom);
            b.meta = 1'($urandom);
            b.seq  = (bad && i == n - 1 && n > 1) ? sq + 1'b1 : sq;
            b.last = (i == n - 1);
            if (b.last) b.eob = $urandom_range(0, 1) ? EOB_LAST : EOB_LAST_PAD;
            else        b.eob = $urandom_range(0, 1) ? EOB_MIDDLE : EOB_RSVD;
            if (s == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    // done_mode: 0 never, 1 random, 2 exactly on a frame's last beat, 3 always.
    task automatic cycle(input int rd_pct, input int done_mode);
        beat_t h[2];
        bit    rq[2];
        bit    rd_e[2];
        bit    lastx;
        int    inc, dec;
        logic [1:0] eg;
        @(negedge clk);
        h[0] = (q0.size() > 0) ? q0[0] : idle_beat();
        h[1] = (q1.size() > 0) ? q1[0] : idle_beat();
        drive(0, h[0]);
        drive(1, h[1]);
        is_arb_rd = ($urandom_range(0, 99) < rd_pct);
        eg = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
        for (int s = 0; s < 2; s++) begin
            rq[s]   = (h[s].vld != 0);
            rd_e[s] = (m_owner == s) && is_arb_rd && rq[s];
        end
        lastx = (m_owner >= 0) && rd_e[m_owner] && h[m_owner].last;
        case (done_mode)
            1:       is_done = ($urandom_range(0, 3) == 0);
            2:       is_done = lastx;
            3:       is_done = 1'b1;
            default: is_done = 1'b0;
        endcase
        #1;
        chk("grant", arb_grant, eg);
        chk("inflight", arb_inflight, 64'(m_infl));
        chk("rd0", is_sc0_rd, rd_e[0]);
        chk("rd1", is_sc1_rd, rd_e[1]);
        chk("frames0", arb_frames0, 64'(m_frames[0]));
        chk("frames1", arb_frames1, 64'(m_frames[1]));
        chk("err_seq", arb_err_seq, m_err);
        if (m_owner >= 0) begin
            chk("arb_vld", arb_is_vld, h[m_owner].vld);
            chk("arb_sym", arb_is_sym, h[m_owner].sym);
            chk("arb_cnt", arb_is_cnt, h[m_owner].cnt);
            chk("arb_meta", arb_is_meta, h[m_owner].meta);
            chk("arb_seq", arb_is_seq_id, h[m_owner].seq);
            chk("arb_eob", arb_is_eob, h[m_owner].eob);
        end else begin
            chk("arb_vld_idle", arb_is_vld, 0);
        end
        @(posedge clk);
        inc = 0;
        dec = 0;
        if (m_owner < 0) begin
            if (m_infl < MI && (rq[0] || rq[1])) begin
                m_owner = (rq[0] && rq[1]) ? m_pref : (rq[0] ? 0 : 1);
                m_first = 1'b1;
            end
        end else if (rd_e[m_owner]) begin
            if (m_first) m_seq = h[m_owner].seq;
            else if (h[m_owner].seq != m_seq) m_err = 1'b1;
            m_first = 1'b0;
            if (m_owner == 0) q0.delete(0); else q1.delete(0);
            if (h[m_owner].last) begin
                if (m_frames[m_owner] < 65535) m_frames[m_owner]++;
                inc = 1;
                m_pref = 1 - m_owner;
                m_owner = -1;
            end
        end
        if (is_done && m_infl > 0) dec = 1;
        m_infl = m_infl + inc - dec;
    endtask

    // Sources keep presenting a valid beat and rd is high, so any rd/vld leak shows.
    task automatic do_reset();
        beat_t b;
        b = idle_beat();
        b.vld = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        drive(0, b);
        drive(1, b);
        is_arb_rd = 1'b1;
        is_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_grant", arb_grant, 0);
            chk("rst_inflight", arb_inflight, 0);
            chk("rst_frames0", arb_frames0, 0);
            chk("rst_frames1", arb_frames1, 0);
            chk("rst_err", arb_err_seq, 0);
            chk("rst_vld", arb_is_vld, 0);
            chk("rst_rd", {is_sc1_rd, is_sc0_rd}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, idle_beat());
        drive(1, idle_beat());
        is_arb_rd = 1'b0;
        is_done = 1'b0;
        q0.delete();
        q1.delete();
        m_owner = -1; m_pref = 0; m_infl = 0;
        m_frames[0] = 0; m_frames[1] = 0;
        m_err = 1'b0; m_first = 1'b1; m_seq = '0;
    endtask

    initial begin
        drive(0, idle_beat());
        drive(1, idle_beat());
        is_arb_rd = 1'b0;
        is_done = 1'b0;
        do_reset();

        // Both sources contend with 3-beat frames; inflight caps the third grant.
        gen_frame(0, 3, 0, 8'h10); gen_frame(0, 3, 0, 8'h11);
        gen_frame(1, 3, 0, 8'h20); gen_frame(1, 3, 0, 8'h21);
        repeat (12) cycle(100, 0);
        chk("cap_inflight", arb_inflight, 2);
        chk("cap_no_grant", arb_grant, 0);
        cycle(100, 3);
        repeat (6) cycle(100, 0);
        chk("after_done_frames0", arb_frames0, 2);

        // Stalled engine mid-frame while the other source requests.
        do_reset();
        gen_frame(0, 4, 0, 8'h30);
        gen_frame(1, 2, 0, 8'h40);
        repeat (2) cycle(100, 0);
        repeat (5) cycle(0, 0);
        chk("stall_grant_hold", arb_grant, 2'b01);
        repeat (10) cycle(100, 0);

        // Last beat coincident with is_done at inflight 1.
        cycle(100, 3);
        gen_frame(0, 2, 0, 8'h50);
        repeat (4) cycle(100, 2);
        chk("inc_dec_inflight", arb_inflight, 1);

        // seq_id 5 then 6 inside one frame; error is sticky across frames.
        do_reset();
        gen_frame(0, 2, 1, 8'd5);
        gen_frame(1, 1, 0, 8'd9);
        gen_frame(0, 3, 0, 8'd7);
        repeat (12) cycle(100, 1);
        chk("err_sticky", arb_err_seq, 1);

        // Reset two beats into a four-beat frame abandons it uncounted.
        do_reset();
        gen_frame(0, 4, 0, 8'h60);
        repeat (3) cycle(100, 0);
        do_reset();
        chk("abandon_frames0", arb_frames0, 0);

        // Randomized traffic, including single-beat frames and seq faults.
        for (int n = 0; n < 3000; n++) begin
            if (q0.size() == 0 && $urandom_range(0, 9) < 4)
                gen_frame(0, $urandom_range(1, 4), ($urandom_range(0, 19) == 0), 8'($urandom));
            if (q1.size() == 0 && $urandom_range(0, 9) < 4)
                gen_frame(1, $urandom_range(1, 4), ($urandom_range(0, 19) == 0), 8'($urandom));
            cycle(75, 1);
            if (n == 1500) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
